// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared encodings for the scoreboarded register file
package rf_pkg;

  localparam logic [1:0] WR_RS   = 2'b00;
  localparam logic [1:0] WR_RT   = 2'b01;
  localparam logic [1:0] WR_LINK = 2'b10;
  localparam logic [1:0] WR_NONE = 2'b11;

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with set/clear and two read taps
module rf_scoreboard #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] tap1_addr,
  input  logic [ADDR_W-1:0] tap2_addr,
  output logic              tap1,
  output logic              tap2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;

  // The set is scheduled after the clear so a same-address alloc keeps the bit high.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_addr] <= 1'b0;
      if (set_en) busy[set_addr] <= 1'b1;
    end
  end

  assign tap1 = busy[tap1_addr];
  assign tap2 = busy[tap2_addr];

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with busy scoreboard and reset sweep
// Optional write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [1:0]        wr_sel,
  input  logic              wen,
  input  logic [DATA_W-1:0] wdata,
  input  logic              alloc_valid,
  input  logic [ADDR_W-1:0] alloc_addr,
  output logic              ready,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state = ST_SWEEP;
  logic [ADDR_W-1:0] ptr   = '0;
  logic [ADDR_W-1:0] dest;
  logic              wr_ok;
  logic              alloc_ok;
  logic              sb_busy1;
  logic              sb_busy2;

  assign ready = (state == ST_RUN);

  always_comb begin
    dest = rs;
    case (wr_sel)
      WR_RS:   dest = rs;
      WR_RT:   dest = rt;
      default: dest = ADDR_W'(LINK_REG);
    endcase
  end

  assign wr_ok    = ready && wen && (wr_sel != WR_NONE) &&
                    !((ZERO_REG != 0) && (dest == '0));
  assign alloc_ok = ready && alloc_valid &&
                    !((ZERO_REG != 0) && (alloc_addr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SWEEP;
      ptr   <= '0;
    end else if (state == ST_SWEEP) begin
      ptr <= ptr + 1'b1;
      if (ptr == {ADDR_W{1'b1}}) state <= ST_RUN;
    end
  end

  // Array has no reset of its own; the sweep clears one entry per cycle instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_SWEEP) mem[ptr] <= '0;
      else if (wr_ok)        mem[dest] <= wdata;
    end
  end

  rf_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (alloc_ok),
    .set_addr (alloc_addr),
    .clr_en   (wr_ok),
    .clr_addr (dest),
    .tap1_addr(rs),
    .tap2_addr(rt),
    .tap1     (sb_busy1),
    .tap2     (sb_busy2)
  );

  always_comb begin
    rdata1 = mem[rs];
    rdata2 = mem[rt];
    busy1  = sb_busy1;
    busy2  = sb_busy2;
`ifdef RF_BYPASS_EN
    if (wr_ok && dest == rs) begin
      rdata1 = wdata;
      if (!(alloc_ok && alloc_addr == rs)) busy1 = 1'b0;
    end
    if (wr_ok && dest == rt) begin
      rdata2 = wdata;
      if (!(alloc_ok && alloc_addr == rt)) busy2 = 1'b0;
    end
`endif
    if ((ZERO_REG != 0) && rs == '0) begin
      rdata1 = '0;
      busy1  = 1'b0;
    end
    if ((ZERO_REG != 0) && rt == '0) begin
      rdata2 = '0;
      busy2  = 1'b0;
    end
    if (!ready) begin
      rdata1 = '0;
      rdata2 = '0;
      busy1  = 1'b0;
      busy2  = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb (ZERO_REG=1 and ZERO_REG=0 instances)
module tb_regfile_sb;
  import rf_pkg::*;

  localparam int SIG_READY = 0, SIG_RD1 = 1, SIG_RD2 = 2, SIG_B1 = 3, SIG_B2 = 4,
                 SIG_Z0_RD1 = 5, SIG_Z0_B1 = 6;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rs = '0, rt = '0, alloc_addr = '0;
  logic [1:0]  wr_sel = WR_NONE;
  logic        wen = 1'b0, alloc_valid = 1'b0;
  logic [31:0] wdata = '0;
  logic        ready, busy1, busy2, ready_z, busy1_z, busy2_z;
  logic [31:0] rdata1, rdata2, rdata1_z, rdata2_z;

  chk_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_sb #(.ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .wr_sel(wr_sel), .wen(wen), .wdata(wdata),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .ready(ready),
    .rdata1(rdata1), .rdata2(rdata2), .busy1(busy1), .busy2(busy2)
  );

  regfile_sb #(.ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .wr_sel(wr_sel), .wen(wen), .wdata(wdata),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .ready(ready_z),
    .rdata1(rdata1_z), .rdata2(rdata2_z), .busy1(busy1_z), .busy2(busy2_z)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input int sig, input logic [31:0] exp, input string name);
    chk_t c;
    c.cyc  = cyc;
    c.sig  = sig;
    c.exp  = exp;
    c.name = name;
    q.push_back(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic expect_sweep(input string name);
    for (int i = 0; i < 32; i++) begin
      expect_sig(SIG_READY, 32'd0, name);
      step();
    end
    expect_sig(SIG_READY, 32'd1, {name, "_rise"});
  endtask

  // Monitor: compares every queued expectation during the cycle it was issued for.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      case (c.sig)
        SIG_READY:  act = {31'd0, ready};
        SIG_RD1:    act = rdata1;
        SIG_RD2:    act = rdata2;
        SIG_B1:     act = {31'd0, busy1};
        SIG_B2:     act = {31'd0, busy2};
        SIG_Z0_RD1: act = rdata1_z;
        default:    act = {31'd0, busy1_z};
      endcase
      checks++;
      if (c.cyc != cyc || act !== c.exp) begin
        errors++;
        $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d/%0d)", c.name, act, c.exp, cyc, c.cyc);
      end
    end
  end

  initial begin
    do_reset();
    expect_sig(SIG_RD1, 32'd0, "rd1_during_sweep");
    expect_sweep("init_sweep");

    // preload r7, then reset with writes and allocs held active through the sweep
    rs = 5'd7; wr_sel = WR_RS; wen = 1'b1; wdata = 32'hDEADBEEF;
    step();
    wen = 1'b0;
    expect_sig(SIG_RD1, 32'hDEADBEEF, "preload_r7");
    step();
    do_reset();
    wen = 1'b1; wdata = 32'h1234; alloc_valid = 1'b1; alloc_addr = 5'd7;
    expect_sig(SIG_B1, 32'd0, "busy_forced_sweep");
    expect_sweep("sweep2");
    wen = 1'b0; alloc_valid = 1'b0;
    expect_sig(SIG_RD1, 32'd0, "r7_cleared");
    expect_sig(SIG_B1, 32'd0, "r7_not_busy");
    step();

    // reset again part-way through the sweep
    do_reset();
    repeat (10) step();
    expect_sig(SIG_READY, 32'd0, "mid_sweep_ready");
    do_reset();
    expect_sweep("restart_sweep");
    step();

    // destination select
    rs = 5'd3; rt = 5'd4; wen = 1'b1;
    wr_sel = WR_RS;   wdata = 32'h11; step();
    wr_sel = WR_RT;   wdata = 32'h22; step();
    wr_sel = WR_LINK; wdata = 32'h33; step();
    wr_sel = WR_NONE; wdata = 32'h44; step();
    wen = 1'b0;
    expect_sig(SIG_RD1, 32'h11, "dest_rs_r3");
    expect_sig(SIG_RD2, 32'h22, "dest_rt_r4");
    step();
    rs = 5'd31; rt = 5'd5;
    expect_sig(SIG_RD1, 32'h33, "dest_link_r31");
    expect_sig(SIG_RD2, 32'd0, "r5_untouched");
    step();
    rs = 5'd30; rt = 5'd1;
    expect_sig(SIG_RD1, 32'd0, "r30_untouched");
    expect_sig(SIG_RD2, 32'd0, "r1_untouched");
    step();

    // zero register: write then alloc
    rs = 5'd0; wr_sel = WR_RS; wen = 1'b1; wdata = 32'h55; step();
    wen = 1'b0; alloc_valid = 1'b1; alloc_addr = 5'd0; step();
    alloc_valid = 1'b0;
    expect_sig(SIG_RD1, 32'd0, "zero_rd1");
    expect_sig(SIG_B1, 32'd0, "zero_busy1");
    expect_sig(SIG_Z0_RD1, 32'h55, "nozero_rd1");
    expect_sig(SIG_Z0_B1, 32'd1, "nozero_busy1");
    step();

    // scoreboard: alloc, write+alloc same edge, write alone
    rs = 5'd9; alloc_valid = 1'b1; alloc_addr = 5'd9; step();
    alloc_valid = 1'b0;
    expect_sig(SIG_B1, 32'd1, "sb_alloc");
    wen = 1'b1; wr_sel = WR_RS; wdata = 32'h99; alloc_valid = 1'b1; step();
    wen = 1'b0; alloc_valid = 1'b0;
    expect_sig(SIG_B1, 32'd1, "sb_set_wins");
    expect_sig(SIG_RD1, 32'h99, "sb_r9_data");
    wen = 1'b1; step();
    wen = 1'b0;
    expect_sig(SIG_B1, 32'd0, "sb_cleared");

    // double alloc then one write clears, observed on the rt tap
    rt = 5'd12; alloc_valid = 1'b1; alloc_addr = 5'd12; step(); step();
    alloc_valid = 1'b0;
    expect_sig(SIG_B2, 32'd1, "sb_double_alloc");
    wen = 1'b1; wr_sel = WR_RT; wdata = 32'h12; step();
    wen = 1'b0;
    expect_sig(SIG_B2, 32'd0, "sb_single_clear");
    step();

    // bypass: sampled while the write is pending
    rs = 5'd5; wr_sel = WR_RS; wen = 1'b1; wdata = 32'hA5A5;
`ifdef RF_BYPASS_EN
    expect_sig(SIG_RD1, 32'hA5A5, "bypass_rd1");
`else
    expect_sig(SIG_RD1, 32'd0, "nobypass_rd1");
`endif
    expect_sig(SIG_B1, 32'd0, "bypass_busy1");
    step();
    wen = 1'b0;
    expect_sig(SIG_RD1, 32'hA5A5, "after_write_r5");
    step();

    // zero register overrides bypass
    rs = 5'd0; wen = 1'b1; wdata = 32'h77;
    expect_sig(SIG_RD1, 32'd0, "zero_over_bypass");
`ifdef RF_BYPASS_EN
    expect_sig(SIG_Z0_RD1, 32'h77, "nozero_bypass");
`else
    expect_sig(SIG_Z0_RD1, 32'h55, "nozero_nobypass");
`endif
    step();
    wen = 1'b0;

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Adds configurable width and depth, an optional hardwired zero register and a per-register busy scoreboard for the pipelined core.
- Replaces the single-cycle bulk clear with a one-entry-per-cycle reset sweep behind a ready flag.
- Sits between decode (read addresses, destination allocation) and writeback (write data).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W (derived localparam).
- LINK_REG, 31, destination index selected by wr_sel = 2'b10.
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and never goes busy; 0: ordinary register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rs  in  ADDR_W  read address 1; also write destination when wr_sel = 00.
- rt  in  ADDR_W  read address 2; also write destination when wr_sel = 01.
- wr_sel  in  2  00 rs, 01 rt, 10 LINK_REG, 11 none.
- wen  in  1  write enable.
- wdata  in  DATA_W  write data.
- alloc_valid  in  1  mark alloc_addr busy (issue of a producer).
- alloc_addr  in  ADDR_W  register to mark busy.
- ready  out  1  1 when the reset sweep is complete.
- rdata1  out  DATA_W  contents of rs (combinational).
- rdata2  out  DATA_W  contents of rt (combinational).
- busy1  out  1  scoreboard bit of rs.
- busy2  out  1  scoreboard bit of rt.

Behaviour:
- FSM states: SWEEP, RUN.
  - rst=1: next state SWEEP, sweep pointer 0, all busy bits cleared, ready=0. Applies from any state, including mid-sweep, where the sweep restarts at 0.
  - SWEEP: each cycle writes 0 to entry[ptr] and increments ptr. On the cycle ptr == DEPTH-1, the next state is RUN.
  - A full sweep takes DEPTH cycles after rst deasserts; ready rises on the following edge.
- Reset values:
  - ready = 0.
  - rdata1, rdata2, busy1, busy2 forced to 0 while ready = 0.
- Power-up without rst: state SWEEP, ptr 0 via initial values. The array is not otherwise initialised.
- While ready = 0, wen and alloc_valid are ignored.
- Write, RUN only:
  - dest = rs, rt or LINK_REG per wr_sel.
  - Write happens on the edge when wen=1 and wr_sel != 11.
  - Write is dropped if dest == 0 and ZERO_REG == 1.
- Read:
  - Asynchronous; returns the array contents.
  - Returns 0 when the address is 0 and ZERO_REG == 1, regardless of the array contents.
- Scoreboard:
  - An accepted write clears busy[dest].
  - alloc_valid sets busy[alloc_addr].
  - Same edge, same address: set wins, so busy stays 1.
  - Alloc to register 0 with ZERO_REG == 1 is ignored.
  - Alloc to an already-busy register keeps busy = 1. No counting.
- Write with wr_sel = 11 or wen = 0: no array change and no busy change.

Optional Feature:
- Macro RF_BYPASS_EN.
- Defined: in RUN, if a write is accepted this cycle and dest == rs, rdata1 = wdata and busy1 = 0 combinationally. Same rule for rt with rdata2/busy2. The rule does not apply when an alloc to that address coincides; busy then shows 1 while data still bypasses.
- Undefined: reads return the pre-edge array value and busy reflects registered state only.
- Zero-register rule overrides the bypass.

Decomposition:
- Package rf_pkg holds:
  - wr_sel encodings: WR_RS = 2'b00, WR_RT = 2'b01, WR_LINK = 2'b10, WR_NONE = 2'b11.
  - FSM state encodings: ST_SWEEP, ST_RUN.
- Sub-module rf_scoreboard: a DEPTH-bit busy vector with set/clear/reset inputs and two read taps.
  - Instantiated once; the sweep FSM and array stay in regfile_sb.

Test Plan:
- Reset and sweep:
  - Stimulus: ADDR_W=5, pre-load register 7 = 0xDEADBEEF, assert rst 1 cycle.
  - Required: ready=0 for exactly 32 cycles, then 1. Reading register 7 returns 0. wen during the sweep has no effect.
- Destination select:
  - Stimulus: wen=1 with wr_sel=00, rs=3, wdata=0x11; then wr_sel=01, rt=4, wdata=0x22; then wr_sel=10, wdata=0x33; then wr_sel=11, wdata=0x44.
  - Required: reg3=0x11, reg4=0x22, reg31=0x33. No other register changes.
- Zero register:
  - Stimulus: ZERO_REG=1; write 0x55 to register 0; alloc register 0.
  - Required: rdata1=0 and busy1=0 with rs=0.
  - Stimulus: ZERO_REG=0, same writes.
  - Required: reads 0x55, busy1=1.
- Scoreboard:
  - Stimulus: alloc register 9; then write register 9 while allocating register 9 on the same edge; then write register 9 only.
  - Required: busy1 (rs=9) reads 1, then 1, then 0.
- Reset mid-sweep:
  - Stimulus: rst pulse at sweep cycle 10.
  - Required: ready stays 0 for 32 cycles after the second rst deasserts.
- Bypass:
  - Stimulus: rs=5, write register 5 = 0xA5A5 with wr_sel=00, sampled before the edge.
  - Required: rdata1 = 0xA5A5 with RF_BYPASS_EN defined; the old value without it.
